// File: rtl/cpu_pkg.sv
// Shared types and instruction-field positions for the Hack-style control stage.
package cpu_pkg;

    // One-hot so each request output is a single flop bit of the state register.
    typedef enum logic [4:0] {
        FETCH  = 5'b00001,
        DECODE = 5'b00010,
        MEMRD  = 5'b00100,
        EXEC   = 5'b01000,
        MEMWR  = 5'b10000
    } state_t;

    localparam int IR_TYPE = 15;
    localparam int A_BIT   = 12;
    localparam int C_MSB   = 11;
    localparam int C_LSB   = 6;
    localparam int D_MSB   = 5;
    localparam int D_LSB   = 3;
    localparam int J_MSB   = 2;
    localparam int J_LSB   = 0;

    localparam int DEST_M = 0;
    localparam int DEST_D = 1;
    localparam int DEST_A = 2;

    localparam int JMP_GT = 0;
    localparam int JMP_EQ = 1;
    localparam int JMP_LT = 2;

endpackage

// File: rtl/cpu_jump_eval.sv
// Combinational jump resolution from the j field and the ALU status flags.
module cpu_jump_eval
    import cpu_pkg::*;
(
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    assign taken = (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~zr & ~ng);

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute/writeback control around an external Hack ALU.
// Optional retired-instruction counter enabled by defining CPU_CONTROL_PERF_CNT_EN.
module cpu_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        mem_wack,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc
`ifdef CPU_CONTROL_PERF_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t      state;
    logic [15:0] ir;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] mdr;
    logic [15:0] wdata;
    logic [14:0] waddr;
    logic [14:0] pc_pend;

    logic        is_c;
    logic        a_sel;
    logic [2:0]  dest;
    logic        taken;
    logic [14:0] pc_inc;
    logic [14:0] pc_exec;

    assign is_c    = ir[IR_TYPE];
    assign a_sel   = ir[A_BIT];
    assign dest    = ir[D_MSB:D_LSB];
    assign pc_inc  = pc + 15'd1;
    assign pc_exec = taken ? a_reg[14:0] : pc_inc;

    cpu_jump_eval u_jump (
        .j     (ir[J_MSB:J_LSB]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (taken)
    );

    assign instr_req  = (state == FETCH);
    assign instr_addr = pc;
    assign mem_rd     = (state == MEMRD);
    assign mem_we     = (state == MEMWR);
    assign mem_addr   = (state == MEMRD) ? a_reg[14:0] :
                        (state == MEMWR) ? waddr : 15'd0;
    assign mem_wdata  = (state == MEMWR) ? wdata : 16'd0;

    // A-instructions carry data in bit 12, so the M operand applies to C-instructions only.
    assign alu_x = d_reg;
    assign alu_y = (is_c & a_sel) ? mdr : a_reg;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[C_MSB:C_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= '0;
            a_reg   <= '0;
            d_reg   <= '0;
            ir      <= '0;
            mdr     <= '0;
            wdata   <= '0;
            waddr   <= '0;
            pc_pend <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_c) begin
                        a_reg <= {1'b0, ir[14:0]};
                        pc    <= pc_inc;
                        state <= FETCH;
                    end else if (a_sel) begin
                        state <= MEMRD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MEMRD: begin
                    if (mem_rvalid) begin
                        mdr   <= mem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (dest[DEST_D]) d_reg <= alu_out;
                    if (dest[DEST_A]) a_reg <= alu_out;
                    // Address and jump target both use A as it was before this write.
                    wdata   <= alu_out;
                    waddr   <= a_reg[14:0];
                    pc_pend <= pc_exec;
                    if (dest[DEST_M]) begin
                        state <= MEMWR;
                    end else begin
                        pc    <= pc_exec;
                        state <= FETCH;
                    end
                end
                MEMWR: begin
                    if (mem_wack) begin
                        pc    <= pc_pend;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef CPU_CONTROL_PERF_CNT_EN
    logic retire;

    assign retire = ((state == DECODE) && !is_c) ||
                    ((state == EXEC) && !dest[DEST_M]) ||
                    ((state == MEMWR) && mem_wack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Randomized bench for cpu_control against an instruction-level Hack reference model.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        mem_rd;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_wack;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;
    logic [14:0] pc;
`ifdef CPU_CONTROL_PERF_CNT_EN
    logic [31:0] retired;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] bm [0:32767];
    logic [15:0] mm [0:32767];
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;

    always #5 clk = ~clk;

    cpu_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_wack    (mem_wack),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_zx      (alu_zx),
        .alu_nx      (alu_nx),
        .alu_zy      (alu_zy),
        .alu_ny      (alu_ny),
        .alu_f       (alu_f),
        .alu_no      (alu_no),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .pc          (pc)
`ifdef CPU_CONTROL_PERF_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'd0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'd0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? xx + yy : xx & yy;
        return c[0] ? ~o : o;
    endfunction

    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
        alu_zr  = (alu_out == 16'd0);
        alu_ng  = alu_out[15];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Executes one instruction through the DUT; fd/rd/wd are extra wait cycles before
    // the fetch valid, the read valid and the write ack respectively.
    task automatic run_instr(input logic [15:0] ins, input int fd, input int rd, input int wd);
        logic [15:0] old_a, y, res;
        logic [14:0] old_pc;
        logic        lt, eq, gt, tk, done;
        int          guard, cyc, rcnt, wcnt, exp_cyc;

        old_a  = m_a;
        old_pc = m_pc;
        res    = 16'd0;
        if (!ins[15]) begin
            m_a     = {1'b0, ins[14:0]};
            m_pc    = m_pc + 15'd1;
            exp_cyc = 2;
        end else begin
            y   = ins[12] ? mm[old_a[14:0]] : old_a;
            res = hack_alu(m_d, y, ins[11:6]);
            lt  = $signed(res) < 0;
            eq  = (res == 16'd0);
            gt  = !lt && !eq;
            tk  = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            if (ins[3]) mm[old_a[14:0]] = res;
            if (ins[4]) m_d = res;
            if (ins[5]) m_a = res;
            m_pc    = tk ? old_a[14:0] : old_pc + 15'd1;
            exp_cyc = 3 + (ins[12] ? rd + 1 : 0) + (ins[3] ? wd + 1 : 0);
        end

        guard = 0;
        while (!instr_req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_addr", {17'd0, instr_addr}, {17'd0, old_pc});

        // Stray handshakes while fetching must be ignored.
        for (int k = 0; k < fd; k++) begin
            mem_rvalid = 1'($urandom % 2);
            mem_wack   = 1'($urandom % 2);
            @(negedge clk);
        end
        mem_rvalid  = 1'b0;
        mem_wack    = 1'b0;
        instr_valid = 1'b1;
        instr_data  = ins;
        @(negedge clk);
        instr_data  = 16'($urandom);

        cyc  = 1;
        rcnt = 0;
        wcnt = 0;
        done = 1'b0;
        while (!done) begin
            if (instr_req) begin
                done = 1'b1;
            end else if (cyc > 40) begin
                check("timeout_cycles", cyc, exp_cyc);
                done = 1'b1;
            end else begin
                instr_valid = 1'($urandom % 2);
                mem_rvalid  = 1'($urandom % 2);
                mem_wack    = 1'($urandom % 2);
                mem_rdata   = 16'($urandom);
                if (mem_rd) begin
                    check("rd_addr", {17'd0, mem_addr}, {17'd0, old_a[14:0]});
                    check("rd_pc_hold", {17'd0, pc}, {17'd0, old_pc});
                    mem_rvalid = (rcnt == rd);
                    if (rcnt == rd) mem_rdata = bm[mem_addr];
                    rcnt++;
                end else if (mem_we) begin
                    check("wr_addr", {17'd0, mem_addr}, {17'd0, old_a[14:0]});
                    check("wr_data", {16'd0, mem_wdata}, {16'd0, res});
                    check("wr_pc_hold", {17'd0, pc}, {17'd0, old_pc});
                    mem_wack = (wcnt == wd);
                    if (wcnt == wd) bm[mem_addr] = mem_wdata;
                    wcnt++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        instr_valid = 1'b0;
        mem_rvalid  = 1'b0;
        mem_wack    = 1'b0;

        check("latency", cyc, exp_cyc);
        check("rd_cycles", rcnt, (ins[15] && ins[12]) ? rd + 1 : 0);
        check("wr_cycles", wcnt, (ins[15] && ins[3]) ? wd + 1 : 0);
        check("pc", {17'd0, pc}, {17'd0, m_pc});
        check("d_reg", {16'd0, alu_x}, {16'd0, m_d});
        if (!ins[15] || !ins[12]) check("a_reg", {16'd0, alu_y}, {16'd0, m_a});
        if (ins[15])
            check("alu_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                  {26'd0, ins[11:6]});
        check("idle_wdata", {16'd0, mem_wdata}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        for (int i = 0; i < 32768; i++) begin
            bm[i] = 16'($urandom);
            mm[i] = bm[i];
        end
        m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr_data  = 16'h1234;
        mem_rvalid  = 1'b1;
        mem_rdata   = 16'd0;
        mem_wack    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_instr_req", {31'd0, instr_req}, 32'd1);
        check("rst_instr_addr", {17'd0, instr_addr}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_pc", {17'd0, pc}, 32'd0);
        instr_valid = 1'b0;
        mem_rvalid  = 1'b0;
        mem_wack    = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);

        run_instr(16'h0005, 0, 0, 0);
        run_instr(16'hEC10, 0, 0, 0);
        run_instr(16'h0003, 1, 0, 0);
        run_instr(16'hE308, 0, 0, 3);
        run_instr(16'h0010, 0, 0, 0);
        run_instr(16'hEA90, 0, 0, 0);
        run_instr(16'hE302, 0, 0, 0);
        run_instr(16'h0010, 0, 0, 0);
        run_instr(16'hEFD0, 0, 0, 0);
        run_instr(16'hE302, 0, 0, 0);
        run_instr(16'h7FFF, 0, 0, 0);
        run_instr(16'hEA87, 0, 0, 0);
        run_instr(16'h0001, 0, 0, 0);
        run_instr(16'h0004, 0, 0, 0);
        run_instr(16'hFC10, 0, 2, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 4) ins = {1'b0, 15'($urandom)};
            else ins = {3'b111, 13'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Abort a pending read with reset.
        run_instr(16'hEFD0, 0, 0, 0);
        run_instr(16'h0123, 0, 0, 0);
        instr_valid = 1'b1;
        instr_data  = 16'hFC10;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_rd_before", {31'd0, mem_rd}, 32'd1);
        check("abort_addr_before", {17'd0, mem_addr}, 32'h123);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("abort_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("abort_pc", {17'd0, pc}, 32'd0);
        check("abort_a", {16'd0, alu_y}, 32'd0);
        check("abort_d", {16'd0, alu_x}, 32'd0);
        check("abort_instr_req", {31'd0, instr_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0;
        run_instr(16'h0007, 0, 0, 0);
        run_instr(16'hE7C8, 0, 1, 2);
        run_instr(16'hFC10, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multi-cycle control and writeback stage for the 16-bit Hack-style datapath. Fetches an instruction, decodes it, drives operands and the six control bits into the ALU, then consumes the ALU's `out`/`zr`/`ng` to update the A/D registers, write memory and resolve jumps. It owns A, D and the PC and sits directly around the ALU, on both its input and its output side.

## Interface
- Parameters: none; all widths are fixed by the instruction set.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_req` out 1: fetch request, asserted in FETCH.
- `instr_addr` out 15: PC value presented for the fetch.
- `instr_valid` in 1: the instruction word is valid this cycle.
- `instr_data` in 16: the instruction word.
- `mem_rd` out 1: data-memory read request.
- `mem_we` out 1: data-memory write request.
- `mem_addr` out 15: `A[14:0]` as it was before this instruction.
- `mem_wdata` out 16: write data.
- `mem_rvalid` in 1: read data is valid.
- `mem_rdata` in 16: read data.
- `mem_wack` in 1: write accepted.
- `alu_x`, `alu_y` out 16: ALU operands. `alu_x` = D. `alu_y` = A, or M when a=1.
- `alu_zx`, `alu_nx`, `alu_zy`, `alu_ny`, `alu_f`, `alu_no` out 1 each: taken from `ir[11:6]`.
- `alu_out` in 16, `alu_zr` in 1, `alu_ng` in 1: results from the combinational ALU.
- `pc` out 15: the architectural PC.

## Operation
- Encoding:
  - A-instruction: `ir[15]=0`. A ← {0, `ir[14:0]`}.
  - C-instruction: `ir[15]=1`. Fields are a=`ir[12]`, c=`ir[11:6]`, d=`ir[5:3]` (A, D, M) and j=`ir[2:0]` (lt, eq, gt).
- FETCH:
  - `instr_req`=1, `instr_addr`=pc.
  - When `instr_valid`=1: ir ← `instr_data`, go to DECODE.
- DECODE:
  - A-instruction: load A, pc ← pc+1, go to FETCH.
  - C-instruction with a=1: go to MEMRD.
  - C-instruction with a=0: go to EXEC.
- MEMRD:
  - `mem_rd`=1, `mem_addr`=A.
  - When `mem_rvalid`=1: mdr ← `mem_rdata`, go to EXEC.
- EXEC: the ALU is combinational, so its result is used in the same cycle.
  - Register writes: d[1] → D ← `alu_out`. d[2] → A ← `alu_out`.
  - Write-back latches: wdata ← `alu_out` and waddr ← old A. Latch these even when d[0]=0.
  - Jump decision: taken = (j[2]&ng) | (j[1]&zr) | (j[0]&~zr&~ng). The target is old `A[14:0]`.
  - If d[0]=1: go to MEMWR.
  - Otherwise: pc ← taken ? target : pc+1, then go to FETCH.
- MEMWR:
  - `mem_we`=1, `mem_addr`=waddr, `mem_wdata`=wdata.
  - When `mem_wack`=1: apply the latched PC update, go to FETCH.
- Arithmetic: pc+1 is modulo 2^15, so 0x7FFF wraps to 0x0000.
- j=000: never jump. j=111: always jump.
- Reset (`rst_n` low):
  - State = FETCH; pc, A, D, ir and mdr cleared.
  - `mem_rd`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `instr_req` = 1 and `instr_addr` = 0. Fetch logic ignores the request while reset is held.
- Reset mid-operation aborts immediately. Any pending memory request drops in the same cycle and there is no partial register update.

## Timing
- All state and registers update on the rising edge of `clk`.
- `mem_*` and `instr_req` are pure decodes of the state register: glitch-free and stable through a wait.
- Handshakes: each request stays asserted until its valid/ack is sampled high. Ack/valid outside the matching state is ignored.
- Minimum latency, counted with single-cycle handshakes:
  - A-instruction: 2 cycles.
  - C-instruction with a=0 and no M destination: 3 cycles.
  - C-instruction with a=1: +1 cycle.
  - M destination: +1 cycle.
- `alu_*` outputs are valid in EXEC only. They are held at the ir/register-derived values at all other times.

## Configuration
- `CPU_CONTROL_PERF_CNT_EN`: when defined, adds output `retired` (out, 32 bits).
  - Reset to 0.
  - Increments by 1 on every transition into FETCH from DECODE, EXEC or MEMWR.
  - Wraps modulo 2^32.
- When not defined, the port and the counter are absent and all other behaviour is identical.

## Structure
- `cpu_pkg` holds:
  - The state enum (FETCH, DECODE, MEMRD, EXEC, MEMWR).
  - Field-position constants for a, c, d and j.
  - Destination and jump-bit localparams.
- Sub-module `cpu_jump_eval`: combinational. Takes j, zr and ng; produces `taken`.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset, then supply `instr_data`=0x0005 → A=0x0005, pc=1, `instr_req` high again 2 cycles after `instr_valid`.
- A=5, then D=A (0xEC10) → `alu_zx..no`=110000, D=0x0005, pc=2.
- A=3, M=D with D=5 (0xE308), `mem_wack` delayed 3 cycles → `mem_we` held 4 cycles with addr=3 and wdata=5. PC advances only after the ack.
- A=0x0010, D;JEQ (0xE302) with D=0 → pc=0x0010. With D=1 → pc increments.
- pc=0x7FFF executing an A-instruction → pc wraps to 0x0000.
- Assert `rst_n` low during MEMRD → `mem_rd` drops immediately, pc=A=D=0. After release, fetch resumes from address 0.
